status_serial_tx: RTL and testbench
===================================

// Module: status_serial_tx
// PURPOSE
//   Serializing transmitter for the status word. Accepts a parallel DATA_W-bit status word via
//   load/ack and sends it LSB-first on the single-bit line ival as a framed sequence
//   (start, data, optional even parity, stop); ival feeds the expr block's serial input.
//   Sits beside the status-generation logic and drives ival in the sysclk domain.
// PARAMETERS
//   DATA_W     9   width of status word / data bits per frame (1..16)
//   BIT_DIV    4   sysclk cycles per serial bit (2..255)
//   PARITY_EN  1   1: insert even-parity bit after data; 0: no parity bit
// PORTS
//   sysclk       in   1        clock, all logic on rising edge
//   reset        in   1        asynchronous reset, active-low
//   load         in   1        request to send status_in; level, sampled every cycle
//   status_in    in   DATA_W   status word, captured on the accepting edge only
//   ack          out  1        one-cycle pulse: status_in captured this edge
//   busy         out  1        frame in progress (START..STOP)
//   drop         out  1        one-cycle pulse: load high while busy, request ignored
//   frames_sent  out  8        count of completed frames, wraps 255->0
//   ival         out  1        serial line, idle high
// BEHAVIOUR
//   - Reset (reset=0, async): state IDLE, ival=1, busy=0, ack=0, drop=0, frames_sent=0,
//     bit/div counters=0. Asserting reset mid-frame aborts it: ival goes high at once, no count.
//   - All outputs registered; no combinational path from inputs to outputs.
//   - FSM states: IDLE, START, DATA, PARITY, STOP.
//     IDLE:   load=1 on edge k -> shift_reg<=status_in, parity<=^status_in, ack=1 for cycle
//             k+1, state START, busy=1 and ival=0 from cycle k+1.
//     START:  ival=0 for BIT_DIV cycles -> DATA.
//     DATA:   ival=shift_reg[0]; every BIT_DIV cycles shift right, bit_cnt++; after DATA_W
//             bits -> PARITY if PARITY_EN else STOP.
//     PARITY: ival=^data (even: total ones in data+parity even) for BIT_DIV cycles -> STOP.
//     STOP:   ival=1 for BIT_DIV cycles -> IDLE; frames_sent++ on the same edge.
//   - Frame length = (2+DATA_W+PARITY_EN)*BIT_DIV cycles; default 48 cycles.
//   - busy drops on the edge entering IDLE. Back-to-back: load high in first IDLE cycle is
//     accepted on that edge; gap between stop bit end and next start bit = exactly 1 cycle.
//   - load=1 while busy=1: ignored, drop pulses in the following cycle, frame undisturbed;
//     status_in changes during a frame have no effect.
//   - Held load: one frame per accept; remaining high after accept while busy produces drop
//     each cycle (upstream must deassert on ack).
//   - Divider counts 0..BIT_DIV-1 and restarts at each bit boundary; no drift across frame.
//   - frames_sent increments modulo 256; 255 + one frame -> 0.
// TESTING
//   1 Reset: hold reset=0 5 cycles with load=1 -> ival=1, busy=0, ack=0, frames_sent=0.
//   2 Single frame, defaults: status_in=9'h1A5, load pulse -> ack next cycle; ival = 0,
//     1,0,1,0,0,1,0,1,1, parity 1 (5 ones), stop 1, each bit 4 cycles; busy 48 cycles; count=1.
//   3 PARITY_EN=0, DATA_W=9, status_in=9'h000 -> 44-cycle frame, 10 low bits then high stop.
//   4 Load held high 200 cycles -> frames every 49 cycles, ack once per frame, drop pulses
//     while busy, frames_sent=4 at end; contents match status_in at each ack.
//   5 Reset asserted 20 cycles into a frame -> ival=1, busy=0 immediately; after release,
//     new load sends full frame, frames_sent=1 only after it completes.
//   6 Wrap: send 256 frames of 9'h0FF -> frames_sent returns to 0; parity bit 0 every frame.

Source files
------------

// File: rtl/status_serial_tx_if.sv
// Load/acknowledge handshake between the status-word producer and the serial transmitter.
interface status_serial_tx_if #(
    parameter int DATA_W = 9
);
    logic              load;
    logic [DATA_W-1:0] status_in;
    logic              ack;
    logic              busy;
    logic              drop;

    modport master (output load, output status_in, input ack, input busy, input drop);
    modport slave  (input load, input status_in, output ack, output busy, output drop);
endinterface

// File: rtl/status_serial_tx.sv
// Framed LSB-first serializer for the status word: start, data, optional even parity, stop.
// Drives the idle-high ival line in the sysclk domain; every output is registered.
module status_serial_tx #(
    parameter int DATA_W    = 9,
    parameter int BIT_DIV   = 4,
    parameter int PARITY_EN = 1
) (
    input  logic                      sysclk,
    input  logic                      reset,
    status_serial_tx_if.slave         bus,
    output logic [7:0]                frames_sent,
    output logic                      ival
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [4:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              ival_q, ival_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;
    logic [7:0]        frames_q, frames_d;
    logic              bit_tick;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d  = state_q;
        div_d    = '0;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        ival_d   = 1'b1;
        ack_d    = 1'b0;
        frames_d = frames_q;
        bit_tick = (div_q == DIV_LAST);

        // Divider restarts at every bit boundary so bit timing cannot drift over the frame.
        if (state_q != IDLE) begin
            div_d = bit_tick ? 8'd0 : div_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d = START;
                    shift_d = bus.status_in;
                    par_d   = ^bus.status_in;
                    bit_d   = '0;
                    ack_d   = 1'b1;
                    ival_d  = 1'b0;
                end
            end
            START: begin
                ival_d = 1'b0;
                if (bit_tick) begin
                    state_d = DATA;
                    ival_d  = shift_q[0];
                end
            end
            DATA: begin
                ival_d = shift_q[0];
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 5'd1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        ival_d  = (PARITY_EN != 0) ? par_q : 1'b1;
                    end else begin
                        ival_d = shift_d[0];
                    end
                end
            end
            PARITY: begin
                ival_d = par_q;
                if (bit_tick) begin
                    state_d = STOP;
                    ival_d  = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d  = IDLE;
                    frames_d = frames_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        // A request seen while a frame is running is refused, never queued.
        drop_d = bus.load && (state_q != IDLE);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            // NOTE: the shift register is reset too; it is small and keeps reset state fully defined.
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            ival_q   <= 1'b1;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge value of the others.
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            ival_q   <= ival_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
            frames_q <= frames_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.busy    = busy_q;
    assign bus.drop    = drop_q;
    assign frames_sent = frames_q;
    assign ival        = ival_q;
endmodule

// File: tb/tb_status_serial_tx.sv
// Bench for status_serial_tx: scoreboard of accepted words checked against the decoded ival line.
module tb_status_serial_tx;
    localparam int DATA_W     = 9;
    localparam int BIT_DIV    = 4;
    localparam int FRAME_BITS = 2 + DATA_W + 1;
    localparam int FRAME_CYC  = FRAME_BITS * BIT_DIV;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] frames_a, frames_b;
    logic       ival_a, ival_b;
    logic [7:0] exp_frames = 8'd0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [DATA_W-1:0] sb_q[$];

    status_serial_tx_if #(.DATA_W(DATA_W)) bus_a ();
    status_serial_tx_if #(.DATA_W(DATA_W)) bus_b ();

    status_serial_tx #(.DATA_W(DATA_W), .BIT_DIV(BIT_DIV), .PARITY_EN(1)) dut_a (
        .sysclk(sysclk), .reset(reset), .bus(bus_a), .frames_sent(frames_a), .ival(ival_a));

    status_serial_tx #(.DATA_W(DATA_W), .BIT_DIV(BIT_DIV), .PARITY_EN(0)) dut_b (
        .sysclk(sysclk), .reset(reset), .bus(bus_b), .frames_sent(frames_b), .ival(ival_b));

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line monitor: decodes every frame on dut_a and compares it with the oldest accepted word.
    initial begin : monitor
        logic [DATA_W-1:0] exp_w, rx_w;
        logic rx_start, rx_par, rx_stop, stable, aborted, bitv;
        forever begin
            @(negedge sysclk);
            if (reset && bus_a.busy === 1'b1 && ival_a === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                    exp_w = '0;
                end else begin
                    exp_w = sb_q.pop_front();
                end
                rx_w = '0; rx_start = 1'b1; rx_par = 1'b0; rx_stop = 1'b0;
                stable = 1'b1; aborted = 1'b0; bitv = 1'b0;
                for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
                    for (int c = 0; c < BIT_DIV && !aborted; c++) begin
                        if (!(b == 0 && c == 0)) @(negedge sysclk);
                        if (!reset) aborted = 1'b1;
                        else begin
                            if (bus_a.busy !== 1'b1) stable = 1'b0;
                            if (c == 0) bitv = ival_a;
                            else if (ival_a !== bitv) stable = 1'b0;
                        end
                    end
                    if (b == 0) rx_start = bitv;
                    else if (b <= DATA_W) rx_w[b-1] = bitv;
                    else if (b == DATA_W + 1) rx_par = bitv;
                    else rx_stop = bitv;
                end
                if (!aborted) begin
                    check("frame_start", rx_start, 0);
                    check("frame_data", rx_w, exp_w);
                    check("frame_parity", rx_par, ^exp_w);
                    check("frame_stop", rx_stop, 1);
                    check("frame_stable", stable, 1);
                end
            end
        end
    end

    task automatic send_a(input logic [DATA_W-1:0] w);
        int cyc;
        logic held, quiet;
        @(negedge sysclk);
        bus_a.load = 1'b1;
        bus_a.status_in = w;
        sb_q.push_back(w);
        @(negedge sysclk);
        bus_a.load = 1'b0;
        bus_a.status_in = ~w;
        check("ack_pulse", bus_a.ack, 1);
        check("busy_start", bus_a.busy, 1);
        cyc = 1;
        held = (frames_a === exp_frames);
        quiet = 1'b1;
        while (bus_a.busy === 1'b1 && cyc < 3 * FRAME_CYC) begin
            @(negedge sysclk);
            if (bus_a.ack !== 1'b0 || bus_a.drop !== 1'b0) quiet = 1'b0;
            if (bus_a.busy === 1'b1) begin
                cyc++;
                if (frames_a !== exp_frames) held = 1'b0;
            end
        end
        exp_frames = exp_frames + 8'd1;
        check("busy_len", cyc, FRAME_CYC);
        check("count_held", held, 1);
        check("ack_drop_quiet", quiet, 1);
        check("frames_sent", frames_a, exp_frames);
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (bus_a.busy !== 1'b0 && n < 3 * FRAME_CYC) begin
            @(negedge sysclk);
            n++;
        end
        check("idle_timeout", bus_a.busy, 0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lows, highs, busyc, acks, drops;
        logic [DATA_W-1:0] w;

        // Reset held with load asserted: nothing may start.
        bus_a.load = 1'b1; bus_a.status_in = 9'h1A5;
        bus_b.load = 1'b1; bus_b.status_in = 9'h000;
        repeat (5) @(negedge sysclk);
        check("rst_ival", ival_a, 1);
        check("rst_busy", bus_a.busy, 0);
        check("rst_ack", bus_a.ack, 0);
        check("rst_drop", bus_a.drop, 0);
        check("rst_frames", frames_a, 0);
        check("rst_ival_b", ival_b, 1);
        bus_a.load = 1'b0;
        bus_b.load = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        check("idle_ival", ival_a, 1);

        // Single default frame.
        send_a(9'h1A5);
        @(negedge sysclk);
        check("idle_after_frame", ival_a, 1);

        // No-parity instance: 10 low bits then the stop bit.
        bus_b.load = 1'b1; bus_b.status_in = 9'h000;
        @(negedge sysclk);
        bus_b.load = 1'b0;
        check("b_ack", bus_b.ack, 1);
        lows = 0; highs = 0; busyc = 0;
        for (int i = 0; i < 44; i++) begin
            if (i > 0) @(negedge sysclk);
            if (i < 40 && ival_b === 1'b0) lows++;
            if (i >= 40 && ival_b === 1'b1) highs++;
            if (bus_b.busy === 1'b1) busyc++;
        end
        @(negedge sysclk);
        check("b_low_bits", lows, 40);
        check("b_stop_bits", highs, 4);
        check("b_busy_len", busyc, 44);
        check("b_busy_end", bus_b.busy, 0);
        check("b_frames", frames_b, 1);

        // Load held through four frame periods with status_in changing every cycle.
        bus_a.load = 1'b1;
        acks = 0; drops = 0;
        for (int j = 0; j <= 4 * (FRAME_CYC + 1); j++) begin
            if (j > 0) @(negedge sysclk);
            if (j > 0) begin
                if (bus_a.ack === 1'b1) acks++;
                if (bus_a.drop === 1'b1) drops++;
            end
            if (j < 4 * (FRAME_CYC + 1)) begin
                w = DATA_W'($urandom);
                bus_a.status_in = w;
                if (j % (FRAME_CYC + 1) == 0) sb_q.push_back(w);
            end else begin
                bus_a.load = 1'b0;
            end
        end
        wait_idle_a();
        exp_frames = exp_frames + 8'd4;
        check("held_acks", acks, 4);
        check("held_drops", drops, 4 * FRAME_CYC);
        check("held_frames", frames_a, exp_frames);

        // Reset 20 cycles into a frame aborts it immediately.
        @(negedge sysclk);
        bus_a.load = 1'b1; bus_a.status_in = 9'h0F0;
        sb_q.push_back(9'h0F0);
        @(negedge sysclk);
        bus_a.load = 1'b0;
        repeat (19) @(negedge sysclk);
        #2 reset = 1'b0;
        #1;
        check("abort_ival", ival_a, 1);
        check("abort_busy", bus_a.busy, 0);
        check("abort_frames", frames_a, 0);
        exp_frames = 8'd0;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        send_a(9'h13C);

        // Wrap of the frame counter from a fresh reset.
        @(negedge sysclk);
        reset = 1'b0;
        exp_frames = 8'd0;
        @(negedge sysclk);
        reset = 1'b1;
        for (int f = 0; f < 256; f++) send_a(9'h0FF);
        check("wrap_frames", frames_a, 0);

        repeat (4) @(negedge sysclk);
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
